// File: rtl/wave_gen.sv
// wave_gen: single-voice waveform generator.
// Each rising edge of the upstream oscillator's at_max level advances an
// 8-bit phase. A square, saw, triangle or LFSR-noise sample is derived from
// that phase and is also rendered as a free-running PWM bit stream.
module wave_gen #(
    parameter int         PWM_W     = 8,     // PWM counter width (only 8 is supported)
    parameter logic [7:0] LFSR_SEED = 8'h01  // noise LFSR reset value, must be nonzero
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       at_max,
    input  logic       enable,
    input  logic [1:0] wave_sel,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       pwm_out
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] SEL_SQUARE = 2'd0;
    localparam logic [1:0] SEL_SAW    = 2'd1;
    localparam logic [1:0] SEL_TRI    = 2'd2;

    logic [0:0]       state_q, state_d;
    logic             at_max_q;
    logic [7:0]       phase_q, phase_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       sample_q, sample_d;
    logic             valid_q, valid_d;
    logic [PWM_W-1:0] pwm_cnt_q;
    logic             pwm_q;

    logic       step;
    logic       take_step;
    logic [7:0] phase_inc;
    logic [7:0] lfsr_next;
    logic [7:0] wave_val;

    // Next-state, step detection, waveform selection and sample computation.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d   = enable ? RUN : IDLE;
        step      = at_max & ~at_max_q & (state_q == RUN);
        // A falling enable clears the voice; a step arriving together with it is dropped.
        take_step = step & enable;
        phase_inc = phase_q + 8'd1;
        // x^8+x^6+x^5+x^4+1, shifted left with the feedback entering bit 0.
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        // Waveform changes only while idle or at the wrap, so a period is
        // never rendered half in one shape and half in another.
        sel_d = sel_q;
        if (state_q == IDLE || (take_step && phase_q == 8'hFF)) begin
            sel_d = wave_sel;
        end

        unique case (sel_d)
            SEL_SQUARE: wave_val = phase_inc[7] ? 8'hFF : 8'h00;
            SEL_SAW:    wave_val = phase_inc;
            SEL_TRI:    wave_val = phase_inc[7] ? ~{phase_inc[6:0], 1'b0}
                                                : {phase_inc[6:0], 1'b0};
            default:    wave_val = lfsr_next;
        endcase

        phase_d  = phase_q;
        lfsr_d   = lfsr_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (!enable) begin
            phase_d  = 8'h00;
            sample_d = 8'h00;
        end else if (take_step) begin
            phase_d  = phase_inc;
            lfsr_d   = lfsr_next;
            sample_d = wave_val;
            valid_d  = 1'b1;
        end
    end

    // Voice state: FSM, edge detector, phase, waveform latch, LFSR and sample.
    always_ff @(posedge clk or negedge nRst) begin
        // NOTE: state registers use non-blocking assignments and reset
        // asynchronously, so every register sees the same pre-edge values.
        if (!nRst) begin
            state_q  <= IDLE;
            at_max_q <= 1'b0;
            phase_q  <= 8'h00;
            sel_q    <= 2'd0;
            lfsr_q   <= LFSR_SEED;
            sample_q <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            at_max_q <= at_max;
            phase_q  <= phase_d;
            sel_q    <= sel_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    // Free-running PWM carrier; the output is high while the counter is below the sample.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            pwm_q     <= (pwm_cnt_q < sample_q);
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign pwm_out      = pwm_q;

endmodule

// File: doc/wave_gen.md
WAVE_GEN -- requirements
Module: wave_gen

Interface
REQ-001 SHALL have parameter PWM_W, default 8, meaning PWM counter width; only 8 is supported.
REQ-002 SHALL have parameter LFSR_SEED, default 8'h01, meaning noise LFSR reset value; must be nonzero.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port at_max  input  1  step request from the upstream oscillator; a level that may stay high for many cycles.
REQ-006 SHALL have port enable  input  1  voice enable (oscillator ON and playSound).
REQ-007 SHALL have port wave_sel  input  2  waveform: 0 square, 1 saw, 2 triangle, 3 noise.
REQ-008 SHALL have port sample  output  8  current unsigned sample.
REQ-009 SHALL have port sample_valid  output  1  one-cycle pulse when sample updates.
REQ-010 SHALL have port pwm_out  output  1  registered PWM rendering of sample.

Function
REQ-011 SHALL implement FSM states IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0; the transition is evaluated every cycle.
REQ-012 SHALL register at_max into at_max_q and define step = at_max & ~at_max_q & (state==RUN); a held-high at_max produces exactly one step.
REQ-013 SHALL, when at_max is already high on the IDLE->RUN cycle, not generate a step until at_max falls and rises again.
REQ-014 SHALL keep an 8-bit phase; on step, phase <= phase+1 modulo 256 (255 wraps to 0).
REQ-015 SHALL latch wave_sel into sel_q only in IDLE or on a step where phase==255; mid-period wave_sel changes take effect at the next wrap.
REQ-016 SHALL compute the next sample from the post-increment phase p and sel_q: square = p[7] ? 8'hFF : 8'h00.
REQ-017 SHALL use saw = p.
REQ-018 SHALL use triangle = p[7] ? ~{p[6:0],1'b0} : {p[6:0],1'b0}.
REQ-019 SHALL use noise = LFSR value after shift.
REQ-020 SHALL implement an 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1, shifting left with feedback into bit0 on every step regardless of sel_q.
REQ-021 SHALL hold the LFSR value across IDLE.
REQ-022 SHALL register sample and pulse sample_valid in the cycle after the clock edge where step was sampled high; latency at_max rise -> sample is 2 clocks.
REQ-023 SHALL, when the FSM enters IDLE, set phase=0 and sample=8'h00 on the next edge, and keep sample_valid=0 while IDLE.
REQ-024 SHALL keep a free-running 8-bit pwm_cnt incrementing every clock and wrapping 255->0.
REQ-025 SHALL drive pwm_out <= (pwm_cnt < sample) as a register: sample 0 gives a constant low, and sample 255 gives high 255 of every 256 cycles.
REQ-026 SHALL, when enable falls on the same cycle as an at_max rise, not take the step; IDLE clearing has priority.

Reset
REQ-027 SHALL, on nRst=0, asynchronously set state=IDLE, phase=0, sel_q=0, at_max_q=0, LFSR=LFSR_SEED, pwm_cnt=0, sample=8'h00, sample_valid=0, pwm_out=0.
REQ-028 SHALL, when reset is asserted mid-period, restart from phase 0 with no sample_valid pulse on the first edge after release.

Verification
REQ-029 SHALL cover: reset, enable=1, wave_sel=1, at_max held high 10 cycles -> exactly one sample_valid, sample=8'h01, 2 clocks after the rise.
REQ-030 SHALL cover: saw, 256 at_max pulses -> sample sequence 1..255 then 0; phase wraps.
REQ-031 SHALL cover: wave_sel=2, 128 steps -> sample reaches 8'hFE at phase 127, then 8'hFF at phase 128.
REQ-032 SHALL cover: wave_sel 0->1 at phase 10 -> square output continues until wrap, and saw starts at the step where phase goes 255->0.
REQ-033 SHALL cover: wave_sel=3 from reset -> first three samples 8'h02, 8'h04, 8'h08, and no 8'h00 over 255 steps.
REQ-034 SHALL cover: sample=8'h40 -> pwm_out high exactly 64 of 256 cycles; enable dropped -> sample=0 and pwm_out low within 2 cycles.
